nird_collector: RTL and testbench
=================================

NIRD_COLLECTOR -- requirements
Module: nird_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the per-frame element counter.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port done_i  input  1  element valid, delayed-stream side.
REQ-006 SHALL have port progress_i  input  1  frame-complete strobe, delayed-stream side.
REQ-007 SHALL have port ni_i  input  4  NI value, sampled when done_i=1.
REQ-008 SHALL have port rd_i  input  4  RD value, sampled when done_i=1.
REQ-009 SHALL have port data_o  output  8  packed element {ni, rd}, with ni in [7:4].
REQ-010 SHALL have port valid_o  output  1  data_o holds a valid element.
REQ-011 SHALL have port ready_i  input  1  downstream accepts the element.
REQ-012 SHALL have port frame_done_o  output  1  one-cycle pulse when a frame is fully drained.
REQ-013 SHALL have port count_o  output  CNT_W  number of elements accepted in the current or last frame.
REQ-014 SHALL have port overflow_o  output  1  sticky flag: an element was dropped.

Function
REQ-015 SHALL accept an element in every cycle where done_i=1 and the FIFO is not full; the input side has no backpressure.
REQ-016 SHALL, when done_i=1 and the FIFO is full with no pop in the same cycle, drop the element, set overflow_o and leave count_o unchanged.
REQ-017 SHALL use the FIFO as first-word-fall-through: valid_o=1 whenever the FIFO is non-empty; data_o is the oldest entry; a pop occurs when valid_o and ready_i are both 1.
REQ-018 SHALL allow a simultaneous push and pop when full; the push then succeeds and occupancy is unchanged.
REQ-019 SHALL keep data_o stable while valid_o=1 and ready_i=0.
REQ-020 SHALL implement an FSM with states IDLE, COLLECT, DRAIN and DONE.
REQ-021 SHALL transition IDLE->COLLECT on the first done_i=1; count_o clears to 0 and then counts that element.
REQ-022 SHALL transition COLLECT->DRAIN on progress_i=1; if done_i=1 in the same cycle, that element is accepted first.
REQ-023 SHALL, in DRAIN, ignore done_i (dropped, overflow_o set) and go to DONE when the FIFO becomes empty.
REQ-024 SHALL, in DONE, assert frame_done_o for exactly one cycle and then return to IDLE.
REQ-025 SHALL treat progress_i=1 in IDLE as a zero-element frame: go directly to DONE, clear count_o to 0, and pulse frame_done_o one cycle later.
REQ-026 SHALL ignore progress_i in DRAIN and DONE.
REQ-027 SHALL saturate count_o at 2^CNT_W-1.
REQ-028 SHALL hold count_o after a frame until the next frame starts.
REQ-029 SHALL wrap the FIFO read and write pointers modulo DEPTH, with full/empty derived from an extra pointer bit.

Reset
REQ-030 SHALL, while rst=0 at a clock edge, set state=IDLE, empty the FIFO, and drive valid_o=0, frame_done_o=0, count_o=0, overflow_o=0 and data_o=0.
REQ-031 SHALL, on reset mid-frame, discard all buffered elements without a frame_done_o pulse.
REQ-032 SHALL clear overflow_o only by reset.

Structure
REQ-033 SHALL place the FSM state encoding (2-bit, IDLE=0, COLLECT=1, DRAIN=2, DONE=3) and packed-element width NIRD_W=8 in the shared package.
REQ-034 SHALL implement the FIFO as one sub-module, nird_fifo (parameters WIDTH, DEPTH), with push/pop/full/empty ports.

Verification
REQ-035 Basic: 5 elements (ni=1..5, rd=9..5) with ready_i=1, then progress_i -> data_o 0x19,0x28,0x37,0x46,0x55 in order, count_o=5, one frame_done_o pulse after the last pop.
REQ-036 Backpressure: ready_i=0 for 20 cycles while DEPTH=16 and 20 elements arrive -> 16 stored, overflow_o=1, count_o=16, the first 16 elements output in order after ready_i=1.
REQ-037 Full with simultaneous pop: FIFO full, done_i=1 and ready_i=1 in the same cycle -> no drop, overflow_o stays 0, occupancy stays 16.
REQ-038 Same-cycle end: last element with done_i=1 and progress_i=1 together -> element output, count includes it, frame_done_o after it drains.
REQ-039 Empty frame: progress_i=1 in IDLE -> count_o=0, frame_done_o high exactly one cycle, valid_o never high.
REQ-040 Mid-frame reset: rst=0 with 7 entries buffered -> next cycle valid_o=0, count_o=0, no frame_done_o; the next frame behaves as in REQ-035.

Source files
------------

// File: rtl/nird_collector_pkg.sv
// nird_collector_pkg: shared FSM encoding and packed-element width for the NI/RD collector
package nird_collector_pkg;
  localparam int NIRD_W = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/nird_fifo.sv
// nird_fifo: first-word-fall-through FIFO; pointers carry an extra wrap bit for full/empty
module nird_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/nird_collector.sv
// nird_collector: gathers {ni,rd} elements per frame into a FIFO and drains them downstream
module nird_collector
  import nird_collector_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic              progress_i,
  input  logic [3:0]        ni_i,
  input  logic [3:0]        rd_i,
  output logic [NIRD_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);
  state_t state, state_nxt;
  logic full, empty, pop, taking, accept;
  assign valid_o = !empty;
  assign pop = valid_o && ready_i;
  assign taking = (state == IDLE) || (state == COLLECT);
  assign accept = done_i && taking && (!full || pop);
  assign frame_done_o = state == DONE;
  nird_fifo #(.WIDTH(NIRD_W), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (pop),
    .din  ({ni_i, rd_i}),
    .dout (data_o),
    .full (full),
    .empty(empty)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE)    ? (done_i ? (progress_i ? DRAIN : COLLECT) : (progress_i ? DONE : IDLE)) :
                (state == COLLECT) ? (progress_i ? DRAIN : COLLECT) :
                (state == DRAIN)   ? (empty ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (done_i && !accept) overflow_o <= 1'b1;
      if (state == IDLE && done_i) count_o <= CNT_W'(1);
      else if (state == IDLE && progress_i) count_o <= '0;
      else if (accept && count_o != '1) count_o <= count_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_nird_collector.sv
// tb_nird_collector: table vectors, directed corner sequences and random traffic against a queue model
module tb_nird_collector;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_DRAIN = 2, PH_DONE = 3;

  logic clk = 1'b0;
  logic rst, done_i, progress_i, ready_i;
  logic [3:0] ni_i, rd_i;
  logic [7:0] data_o;
  logic valid_o, frame_done_o, overflow_o;
  logic [CNT_W-1:0] count_o;

  always #5 clk = ~clk;

  nird_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .done_i      (done_i),
    .progress_i  (progress_i),
    .ni_i        (ni_i),
    .rd_i        (rd_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_done_o(frame_done_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] m_q[$];
  int m_ph, m_cnt;
  bit m_ovf;
  logic obs_valid, obs_fd, obs_ovf;
  logic [7:0] obs_data;
  logic [CNT_W-1:0] obs_cnt;

  typedef struct {
    logic d, p, rdy;
    logic [3:0] ni, rd;
    logic exp_valid;
    logic [7:0] exp_data;
    logic exp_fd;
    int exp_cnt;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ph = PH_IDLE;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  // Frame rules applied at a clock edge from the pre-edge view of the outputs
  task automatic model_edge(input logic d, p, input logic [3:0] n, r, input logic rdy, rs);
    bit pop, acc;
    int sz;
    if (!rs) begin
      model_reset();
      return;
    end
    sz = m_q.size();
    pop = (sz > 0) && rdy;
    acc = d && (m_ph == PH_IDLE || m_ph == PH_COLLECT) && (sz < DEPTH || pop);
    if (d && !acc) m_ovf = 1;
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back({n, r});
    if (m_ph == PH_IDLE && d) m_cnt = 1;
    else if (m_ph == PH_IDLE && p) m_cnt = 0;
    else if (acc && m_cnt < MAXC) m_cnt++;
    case (m_ph)
      PH_IDLE:    m_ph = d ? (p ? PH_DRAIN : PH_COLLECT) : (p ? PH_DONE : PH_IDLE);
      PH_COLLECT: if (p) m_ph = PH_DRAIN;
      PH_DRAIN:   if (sz == 0) m_ph = PH_DONE;
      default:    m_ph = PH_IDLE;
    endcase
  endtask

  task automatic step(input logic d, p, input logic [3:0] n, r, input logic rdy, rs);
    done_i = d; progress_i = p; ni_i = n; rd_i = r; ready_i = rdy; rst = rs;
    #3;
    obs_valid = valid_o; obs_data = data_o; obs_fd = frame_done_o;
    obs_cnt = count_o; obs_ovf = overflow_o;
    chk("valid", 32'(valid_o), 32'(m_q.size() != 0));
    chk("data", 32'(data_o), m_q.size() != 0 ? 32'(m_q[0]) : 32'h0);
    chk("frame_done", 32'(frame_done_o), 32'(m_ph == PH_DONE));
    chk("count", 32'(count_o), 32'(m_cnt));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    @(posedge clk);
    model_edge(d, p, n, r, rdy, rs);
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1, 0);
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].p, tbl[i].ni, tbl[i].rd, tbl[i].rdy, 1);
      chk("tbl_valid", 32'(obs_valid), 32'(tbl[i].exp_valid));
      chk("tbl_data", 32'(obs_data), 32'(tbl[i].exp_data));
      chk("tbl_fd", 32'(obs_fd), 32'(tbl[i].exp_fd));
      chk("tbl_count", 32'(obs_cnt), 32'(tbl[i].exp_cnt));
    end
  endtask

  task automatic drain(output int pops, output bit seen);
    pops = 0;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step(0, 0, 0, 0, 1, 1);
      if (obs_valid) pops++;
      if (obs_fd) seen = 1;
    end
  endtask

  initial begin
    int pops;
    bit seen;
    tbl[0] = '{1, 0, 1, 1, 4'd9, 0, 8'h00, 0, 0};
    tbl[1] = '{1, 0, 1, 2, 4'd8, 1, 8'h19, 0, 1};
    tbl[2] = '{1, 0, 1, 3, 4'd7, 1, 8'h28, 0, 2};
    tbl[3] = '{1, 0, 1, 4, 4'd6, 1, 8'h37, 0, 3};
    tbl[4] = '{1, 0, 1, 5, 4'd5, 1, 8'h46, 0, 4};
    tbl[5] = '{0, 1, 1, 0, 4'd0, 1, 8'h55, 0, 5};
    tbl[6] = '{0, 0, 1, 0, 4'd0, 0, 8'h00, 0, 5};
    tbl[7] = '{0, 0, 1, 0, 4'd0, 0, 8'h00, 1, 5};
    tbl[8] = '{0, 0, 1, 0, 4'd0, 0, 8'h00, 0, 5};
    done_i = 0; progress_i = 0; ni_i = 0; rd_i = 0; ready_i = 0; rst = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_data", 32'(data_o), 0);
    chk("rst_fd", 32'(frame_done_o), 0);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);

    run_table();

    // backpressure: 20 arrivals into 16 slots
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 4'(i), 4'(19 - i), 0, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("bp_count", 32'(obs_cnt), 16);
    chk("bp_overflow", 32'(obs_ovf), 1);
    drain(pops, seen);
    chk("bp_pops", pops, 16);
    chk("bp_frame_done", 32'(seen), 1);

    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 4'(i), 4'(i + 3), 0, 1);
    step(1, 0, 4'hA, 4'hB, 1, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("full_overflow", 32'(obs_ovf), 0);
    drain(pops, seen);
    chk("full_occupancy", pops, 16);
    chk("full_frame_done", 32'(seen), 1);

    // same-cycle last element and progress
    step(1, 0, 4'h3, 4'hC, 1, 1);
    step(1, 1, 4'h7, 4'hE, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("same_count", 32'(obs_cnt), 2);
    chk("same_data", 32'(obs_data), 32'h7E);
    drain(pops, seen);
    chk("same_frame_done", 32'(seen), 1);

    // empty frame
    step(0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("empty_fd_on", 32'(obs_fd), 1);
    chk("empty_count", 32'(obs_cnt), 0);
    step(0, 0, 0, 0, 1, 1);
    chk("empty_fd_off", 32'(obs_fd), 0);
    chk("empty_valid", 32'(obs_valid), 0);

    // reset with 7 entries buffered
    for (int i = 0; i < 7; i++) step(1, 0, 4'(i), 4'(i), 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("mid_count_pre", 32'(obs_cnt), 7);
    do_reset();
    step(0, 0, 0, 0, 1, 1);
    chk("mid_valid", 32'(obs_valid), 0);
    chk("mid_count", 32'(obs_cnt), 0);
    chk("mid_fd", 32'(obs_fd), 0);
    run_table();

    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
